// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared datapath width and read-port state encoding
package processor_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    RD_EMPTY = 1'b0,
    RD_FULL  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/reg_bank_rd_slot.sv
// rtl/reg_bank_rd_slot.sv - one-entry back-pressurable read response slot
module reg_bank_rd_slot
  import processor_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_oor,
  input  logic              i_ready,
  output logic              o_gnt,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_oor
);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic              w_accept;
  logic [DATA_W-1:0] r_data;
  logic              r_oor;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RD_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_gnt       = (r_state == RD_EMPTY) | i_ready;
    w_accept    = i_req & o_gnt;
    case (r_state)
      RD_EMPTY: if (w_accept) w_state_nxt = RD_FULL;
      RD_FULL:  if (i_ready && !w_accept) w_state_nxt = RD_EMPTY;
      default:  w_state_nxt = RD_EMPTY;
    endcase
  end

  // Payload only moves on accept, so a stalled response cannot be disturbed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_oor  <= 1'b0;
    end else if (w_accept) begin
      r_data <= i_data;
      r_oor  <= i_oor;
    end
  end

  assign o_valid = (r_state == RD_FULL);
  assign o_data  = r_data;
  assign o_oor   = r_oor;

endmodule

// File: rtl/reg_bank_rd.sv
// rtl/reg_bank_rd.sv - register bank with load-style write and handshaked read
// Optional macro REG_BANK_ZERO_R0_EN hardwires register 0 to zero.
module reg_bank_rd
  import processor_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_req,
  input  logic [AW-1:0]     i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic              o_rd_oor
);

`ifdef REG_BANK_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_ok;
  logic              w_rd_inr;
  logic              w_rd_zero;
  logic              w_bypass;
  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_slot_data;

  assign w_wr_ok   = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_L)
                     && !(ZERO_R0 && (i_wr_addr == '0));
  assign w_rd_inr  = ({1'b0, i_rd_addr} < DEPTH_L);
  assign w_rd_zero = ZERO_R0 && (i_rd_addr == '0);
  assign w_bypass  = i_wr_en && (i_wr_addr == i_rd_addr) && w_rd_inr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_R0 && i == 0) && (i_wr_addr == AW'(i))) r_mem[i] <= i_wr_data;
      end
    end
  end

  always_comb begin
    w_mem_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr == AW'(i)) w_mem_rd = r_mem[i];
    end
  end

  always_comb begin
    w_slot_data = w_mem_rd;
    if (!w_rd_inr || w_rd_zero) w_slot_data = '0;
    else if (w_bypass)          w_slot_data = i_wr_data;
  end

  reg_bank_rd_slot u_slot (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_rd_req),
    .i_data  (w_slot_data),
    .i_oor   (!w_rd_inr),
    .i_ready (i_rd_ready),
    .o_gnt   (o_rd_gnt),
    .o_valid (o_rd_valid),
    .o_data  (o_rd_data),
    .o_oor   (o_rd_oor)
  );

endmodule

// File: tb/tb_reg_bank_rd.sv
// tb/tb_reg_bank_rd.sv - table-driven scoreboard bench for reg_bank_rd (DEPTH=6)
module tb_reg_bank_rd;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [2:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0;
  logic       i_rd_req = 1'b0;
  logic [2:0] i_rd_addr = '0;
  logic       i_rd_ready = 1'b0;
  logic       o_rd_gnt;
  logic       o_rd_valid;
  logic [7:0] o_rd_data;
  logic       o_rd_oor;

  reg_bank_rd #(.DEPTH(6), .AW(3)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_rd_req   (i_rd_req),
    .i_rd_addr  (i_rd_addr),
    .o_rd_gnt   (o_rd_gnt),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .i_rd_ready (i_rd_ready),
    .o_rd_oor   (o_rd_oor)
  );

  always #5 clk = ~clk;

`ifdef REG_BANK_ZERO_R0_EN
  localparam logic [7:0] R0_EXP = 8'h00;
`else
  localparam logic [7:0] R0_EXP = 8'h77;
`endif

  typedef struct {
    logic [7:0] data;
    logic       oor;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       req;
    logic [2:0] ra;
    logic       rdy;
    logic [7:0] ed;
    logic       eo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  logic m_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic we, input logic [2:0] wa,
                              input logic [7:0] wd, input logic req, input logic [2:0] ra,
                              input logic rdy, input logic [7:0] ed, input logic eo);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.req = req;
    v.ra = ra; v.rdy = rdy; v.ed = ed; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Drive one cycle, check outputs before the edge, advance the model, step past the edge.
  task automatic tick(input logic rst, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic req, input logic [2:0] ra, input logic rdy,
                      input logic [7:0] ed, input logic eo);
    logic m_gnt;
    logic acc;
    i_rst = rst; i_wr_en = we; i_wr_addr = wa; i_wr_data = wd;
    i_rd_req = req; i_rd_addr = ra; i_rd_ready = rdy;
    #1;
    m_gnt = !m_valid || rdy;
    acc   = req && m_gnt;
    if (!rst) begin
      chk("rd_valid", {7'd0, o_rd_valid}, {7'd0, m_valid});
      chk("rd_gnt", {7'd0, o_rd_gnt}, {7'd0, m_gnt});
      if (m_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at %0t: got empty expected entry", $time);
        end else begin
          chk("rd_data", o_rd_data, sb[0].data);
          chk("rd_oor", {7'd0, o_rd_oor}, {7'd0, sb[0].oor});
        end
      end
    end
    if (rst) begin
      sb.delete();
      m_valid = 1'b0;
    end else begin
      if (m_valid && rdy && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back('{data: ed, oor: eo});
      m_valid = acc || (m_valid && !rdy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_after_ff [6];
    exp_after_ff[0] = 8'h00; exp_after_ff[1] = 8'h00; exp_after_ff[2] = 8'h11;
    exp_after_ff[3] = 8'hA5; exp_after_ff[4] = 8'h00; exp_after_ff[5] = 8'h3C;

    tick(1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
    tick(1, 0, 0, 8'h00, 1, 1, 1, 8'h00, 0);
    chk("reset_valid", {7'd0, o_rd_valid}, 8'd0);
    chk("reset_data", o_rd_data, 8'h00);
    chk("reset_oor", {7'd0, o_rd_oor}, 8'd0);

    for (int a = 0; a < 6; a++) vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3'(a), 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 3, 8'hA5, 0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 5, 8'h3C, 1, 5, 1, 8'h3C, 0));
    vecs.push_back(mk(0, 1, 2, 8'h11, 0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 7, 1, 8'h00, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 6, 1, 8'h00, 1));
    vecs.push_back(mk(0, 1, 6, 8'hFF, 0, 0, 1, 8'h00, 0));
    for (int a = 0; a < 6; a++) vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3'(a), 1, exp_after_ff[a], 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0));

    foreach (vecs[i])
      tick(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].req,
           vecs[i].ra, vecs[i].rdy, vecs[i].ed, vecs[i].eo);

    // Stall with a held request while the stalled address is rewritten.
    tick(0, 0, 0, 8'h00, 1, 2, 1, 8'h11, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 1, 2, 8'h22, 1, 2, 0, 8'h22, 0);
      chk("hold_gnt", {7'd0, o_rd_gnt}, 8'd0);
      chk("hold_data", o_rd_data, 8'h11);
    end
    tick(0, 0, 0, 8'h00, 1, 2, 1, 8'h22, 0);
    tick(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0);

    // Reset while a response is stalled and a request is pending.
    tick(0, 0, 0, 8'h00, 1, 3, 1, 8'hA5, 0);
    tick(0, 0, 0, 8'h00, 1, 2, 0, 8'h22, 0);
    tick(1, 0, 0, 8'h00, 1, 2, 0, 8'h00, 0);
    chk("midrst_valid", {7'd0, o_rd_valid}, 8'd0);
    for (int a = 0; a < 6; a++) tick(0, 0, 0, 8'h00, 1, 3'(a), 1, 8'h00, 0);
    tick(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0);

    tick(0, 1, 0, 8'h77, 0, 0, 1, 8'h00, 0);
    tick(0, 0, 0, 8'h00, 1, 0, 1, R0_EXP, 0);
    tick(0, 1, 0, 8'h77, 1, 0, 1, R0_EXP, 0);
    tick(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0);
    chk("final_valid", {7'd0, o_rd_valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
